// File: rtl/uart_menu_pkg.sv
// Shared definitions for the UART menu controller.
//   - ASCII key constants used by the command decoder
//   - state encodings for the text streamer and for the key decoder
package uart_menu_pkg;

    localparam logic [7:0] DIG0  = 8'h30;  // '0'
    localparam logic [7:0] DIG1  = 8'h31;  // '1', first section key
    localparam logic [7:0] KEY_A = 8'h61;  // 'a', first toggle key
    localparam logic [7:0] KEY_Q = 8'h3F;  // '?', menu reprint

    // Byte loop of the ROM streamer: one byte in flight at a time.
    typedef enum logic [2:0] {
        SS_IDLE,
        SS_ADDR,
        SS_ROMW,
        SS_LOAD,
        SS_START,
        SS_WAIT,
        SS_NEXT
    } strm_state_t;

    // Command side: IDLE launches the menu, RUN waits for a stream to end.
    typedef enum logic [1:0] {
        CS_IDLE,
        CS_RUN,
        CS_KEY,
        CS_DISP
    } ctrl_state_t;

endpackage

// File: rtl/uart_menu_ctrl_if.sv
// Byte-level UART handshake between the menu controller and uart_rx/uart_tx.
//   rx_valid/rx_data : received byte strobe from uart_rx
//   tx_start/tx_data : transmit request to uart_tx, data held until tx_done
//   tx_done          : uart_tx finished the current byte
//   master modport   : controller side; slave modport : UART side
interface uart_menu_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;

    modport master (
        input  rx_valid,
        input  rx_data,
        output tx_start,
        output tx_data,
        input  tx_done
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  tx_start,
        input  tx_data,
        output tx_done
    );
endinterface

// File: rtl/uart_menu_ctrl_rom_streamer.sv
// Streams the inclusive ROM range [start_addr, stop_addr] byte by byte to the
// UART transmitter, with a timeout on each byte's tx_done.
//   go         : one-cycle launch, accepted only while idle
//   start_addr/stop_addr : range latched on go (stop<start prints one byte)
//   rom_addr/rom_data    : sync ROM, data valid ROM_LAT cycles after address
//   tx_start/tx_data/tx_done : UART TX byte handshake
//   busy  : high while a range is being streamed
//   done  : one-cycle pulse after the last byte completed
//   abort : one-cycle pulse when tx_done did not arrive within TO_CYC cycles
module rom_streamer
    import uart_menu_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int ROM_LAT = 1,
    parameter int TO_CYC  = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] stop_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic              done,
    output logic              abort
);
    localparam int TW = $clog2(TO_CYC + 1);

    strm_state_t       state_r;
    logic [ADDR_W-1:0] cur_r;
    logic [ADDR_W-1:0] stop_r;
    logic [1:0]        lat_r;
    logic [TW-1:0]     timer_r;

    // Byte loop ADDR -> ROMW -> LOAD -> START -> WAIT -> NEXT with per-byte timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= SS_IDLE;
            cur_r    <= '0;
            stop_r   <= '0;
            lat_r    <= 2'd0;
            timer_r  <= '0;
            rom_addr <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            abort    <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            abort    <= 1'b0;
            case (state_r)
                SS_IDLE: begin
                    if (go) begin
                        cur_r   <= start_addr;
                        // A reversed range collapses to the single start byte.
                        stop_r  <= (stop_addr < start_addr) ? start_addr : stop_addr;
                        busy    <= 1'b1;
                        state_r <= SS_ADDR;
                    end
                end
                SS_ADDR: begin
                    rom_addr <= cur_r;
                    lat_r    <= 2'd0;
                    state_r  <= SS_ROMW;
                end
                SS_ROMW: begin
                    if (lat_r == 2'(ROM_LAT - 1)) begin
                        state_r <= SS_LOAD;
                    end else begin
                        lat_r <= lat_r + 2'd1;
                    end
                end
                SS_LOAD: begin
                    tx_data <= rom_data;
                    state_r <= SS_START;
                end
                SS_START: begin
                    tx_start <= 1'b1;
                    timer_r  <= '0;
                    state_r  <= SS_WAIT;
                end
                SS_WAIT: begin
                    if (tx_done) begin
                        state_r <= SS_NEXT;
                    end else if (timer_r == TW'(TO_CYC - 1)) begin
                        abort   <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= SS_IDLE;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                SS_NEXT: begin
                    if (cur_r == stop_r) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= SS_IDLE;
                    end else begin
                        cur_r   <= cur_r + ADDR_W'(1);
                        state_r <= SS_ADDR;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= SS_IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_menu_ctrl.sv
// UART menu/command controller. Prints the menu from ROM, then decodes single
// key commands: '1'..'0'+N_SECT print a ROM section, 'a'..'a'+N_OUT-1 toggle a
// gpio bit, '?' reprints the menu, anything else is ignored.
//   clk, rst_n   : clock, synchronous active-low reset
//   uart         : byte handshake to uart_rx/uart_tx (master side)
//   rom_addr/rom_data : external sync text ROM
//   gpio_out     : registered toggle outputs
//   busy         : a text stream is active
//   err_timeout  : sticky TX timeout flag
//   key_ok       : one-cycle pulse per accepted command key
module uart_menu_ctrl
    import uart_menu_pkg::*;
#(
    parameter int                       ADDR_W     = 10,
    parameter int                       N_SECT     = 3,
    parameter int                       N_OUT      = 2,
    parameter logic [ADDR_W-1:0]        MENU_START = 10'd0,
    parameter logic [ADDR_W-1:0]        MENU_STOP  = 10'd97,
    parameter logic [ADDR_W*N_SECT-1:0] SECT_START = {10'd163, 10'd106, 10'd98},
    parameter logic [ADDR_W*N_SECT-1:0] SECT_STOP  = {10'd192, 10'd162, 10'd105},
    parameter int                       ROM_LAT    = 1,
    parameter int                       TO_CYC     = 100000000,
    parameter logic [N_OUT-1:0]         OUT_RST    = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_menu_ctrl_if.master     uart,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [7:0]           rom_data,
    output logic [N_OUT-1:0]     gpio_out,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 key_ok
);
    ctrl_state_t       cst_r;
    logic              go_r;
    logic [ADDR_W-1:0] start_r;
    logic [ADDR_W-1:0] stop_r;
    logic              pend_v_r;
    logic [7:0]        pend_d_r;
    logic [7:0]        key_r;
    logic              done_s;
    logic              abort_s;
    logic              sect_hit_s;
    logic [ADDR_W-1:0] sect_lo_s;
    logic [ADDR_W-1:0] sect_hi_s;
    logic [N_OUT-1:0]  tog_mask_s;

    rom_streamer #(
        .ADDR_W  (ADDR_W),
        .ROM_LAT (ROM_LAT),
        .TO_CYC  (TO_CYC)
    ) u_streamer (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go_r),
        .start_addr (start_r),
        .stop_addr  (stop_r),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .tx_start   (uart.tx_start),
        .tx_data    (uart.tx_data),
        .tx_done    (uart.tx_done),
        .busy       (busy),
        .done       (done_s),
        .abort      (abort_s)
    );

    // Decode the latched key into a section range or a toggle mask.
    always_comb begin
        sect_hit_s = 1'b0;
        sect_lo_s  = '0;
        sect_hi_s  = '0;
        tog_mask_s = '0;
        for (int k = 0; k < N_SECT; k++) begin
            if (key_r == (DIG1 + 8'(k))) begin
                sect_hit_s = 1'b1;
                sect_lo_s  = SECT_START[k*ADDR_W +: ADDR_W];
                sect_hi_s  = SECT_STOP[k*ADDR_W +: ADDR_W];
            end else begin
                sect_hit_s = sect_hit_s;
            end
        end
        for (int i = 0; i < N_OUT; i++) begin
            tog_mask_s[i] = (key_r == (KEY_A + 8'(i)));
        end
    end

    // Command FSM, pending key buffer, gpio outputs and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cst_r       <= CS_IDLE;
            go_r        <= 1'b0;
            start_r     <= '0;
            stop_r      <= '0;
            pend_v_r    <= 1'b0;
            pend_d_r    <= 8'h00;
            key_r       <= 8'h00;
            key_ok      <= 1'b0;
            gpio_out    <= OUT_RST;
            err_timeout <= 1'b0;
        end else begin
            go_r   <= 1'b0;
            key_ok <= 1'b0;
            if (abort_s) begin
                err_timeout <= 1'b1;
            end
            // Outside KEY every received byte lands in the buffer, last one wins.
            if (uart.rx_valid && (cst_r != CS_KEY)) begin
                pend_v_r <= 1'b1;
                pend_d_r <= uart.rx_data;
            end
            case (cst_r)
                CS_IDLE: begin
                    start_r <= MENU_START;
                    stop_r  <= MENU_STOP;
                    go_r    <= 1'b1;
                    cst_r   <= CS_RUN;
                end
                CS_RUN: begin
                    if (abort_s) begin
                        cst_r <= CS_IDLE;
                    end else if (done_s) begin
                        cst_r <= CS_KEY;
                    end
                end
                CS_KEY: begin
                    if (pend_v_r) begin
                        // Buffered byte goes first; a fresh byte refills the buffer.
                        key_r <= pend_d_r;
                        if (uart.rx_valid) begin
                            pend_d_r <= uart.rx_data;
                        end else begin
                            pend_v_r <= 1'b0;
                        end
                        cst_r <= CS_DISP;
                    end else if (uart.rx_valid) begin
                        key_r <= uart.rx_data;
                        cst_r <= CS_DISP;
                    end
                end
                CS_DISP: begin
                    if (sect_hit_s) begin
                        key_ok  <= 1'b1;
                        start_r <= sect_lo_s;
                        stop_r  <= sect_hi_s;
                        go_r    <= 1'b1;
                        cst_r   <= CS_RUN;
                    end else if (tog_mask_s != '0) begin
                        key_ok   <= 1'b1;
                        gpio_out <= gpio_out ^ tog_mask_s;
                        cst_r    <= CS_KEY;
                    end else if (key_r == KEY_Q) begin
                        key_ok <= 1'b1;
                        cst_r  <= CS_IDLE;
                    end else begin
                        cst_r <= CS_KEY;
                    end
                end
                default: begin
                    cst_r <= CS_IDLE;
                end
            endcase
        end
    end
endmodule
